// File: rtl/bus_wrr_scheduler.sv
// Weighted round-robin arbiter for a shared bus. Each grant covers one transfer
// and spends one credit. A grant is released on done or after a bounded busy time.
module bus_wrr_scheduler #(
  parameter int unsigned drvrs   = 4,
  parameter int unsigned wght_w  = 4,
  parameter int unsigned timeout = 16,
  localparam int unsigned idx_w  = (drvrs > 1) ? $clog2(drvrs) : 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [drvrs-1:0]  pndng,
  input  logic              done,
  input  logic              cfg_we,
  input  logic [idx_w-1:0]  cfg_idx,
  input  logic [wght_w-1:0] cfg_wght,
  output logic [drvrs-1:0]  gnt,
  output logic              gnt_vld,
  output logic [idx_w-1:0]  gnt_id,
  output logic              timeout_err
);

  localparam int unsigned       tcnt_w    = 8;
  localparam logic [tcnt_w-1:0] tcnt_last = tcnt_w'(timeout - 1);

  typedef enum logic {st_idle = 1'b0, st_busy = 1'b1} state_t;

  state_t            state;
  logic              armed;
  logic [tcnt_w-1:0] tcnt;
  logic [idx_w-1:0]  ptr;
  logic [wght_w-1:0] weight [drvrs];
  logic [wght_w-1:0] credit [drvrs];

  logic [drvrs-1:0]  elig_c;
  logic [drvrs-1:0]  credited_c;
  logic [drvrs-1:0]  cand_c;
  logic              refill_c;
  logic              sel_vld_c;
  logic [idx_w-1:0]  sel_id_c;
  logic              rel_c;
  logic              cfg_hit_c;
  logic [wght_w-1:0] credit_nxt_c [drvrs];

  // Candidates: eligible drivers with credit, or all eligible ones when a refill is due
  always_comb begin
    elig_c     = '0;
    credited_c = '0;
    for (int i = 0; i < int'(drvrs); i++) begin
      elig_c[i]     = pndng[i] && (weight[i] != '0);
      credited_c[i] = elig_c[i] && (credit[i] != '0);
    end
    refill_c = (elig_c != '0) && (credited_c == '0);
    cand_c   = refill_c ? elig_c : credited_c;
  end

  // First candidate at or after ptr, wrapping; descending scan leaves the nearest one
  always_comb begin
    sel_vld_c = 1'b0;
    sel_id_c  = '0;
    for (int k = int'(drvrs) - 1; k >= 0; k--) begin
      if (cand_c[idx_w'((int'(ptr) + k) % int'(drvrs))]) begin
        sel_vld_c = 1'b1;
        sel_id_c  = idx_w'((int'(ptr) + k) % int'(drvrs));
      end
    end
  end

  // Credit update: refill or spend first, then clamp against a weight being written
  always_comb begin
    rel_c     = (state == st_busy) && (done || (tcnt == tcnt_last));
    cfg_hit_c = cfg_we && (32'(cfg_idx) < drvrs);
    for (int i = 0; i < int'(drvrs); i++) begin
      credit_nxt_c[i] = credit[i];
    end
    if ((state == st_idle) && armed && refill_c) begin
      for (int i = 0; i < int'(drvrs); i++) begin
        credit_nxt_c[i] = weight[i];
      end
    end
    if (rel_c && (credit[gnt_id] != '0)) begin
      credit_nxt_c[gnt_id] = credit[gnt_id] - wght_w'(1);
    end
    if (cfg_hit_c && (credit_nxt_c[cfg_idx] > cfg_wght)) begin
      credit_nxt_c[cfg_idx] = cfg_wght;
    end
  end

  // State, grant outputs and per-driver tables
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= st_idle;
      armed       <= 1'b0;
      tcnt        <= '0;
      ptr         <= '0;
      gnt         <= '0;
      gnt_vld     <= 1'b0;
      gnt_id      <= '0;
      timeout_err <= 1'b0;
      for (int i = 0; i < int'(drvrs); i++) begin
        weight[i] <= wght_w'(1);
        credit[i] <= wght_w'(1);
      end
    end else begin
      armed       <= 1'b1;
      timeout_err <= 1'b0;
      credit      <= credit_nxt_c;
      if (cfg_hit_c) begin
        weight[cfg_idx] <= cfg_wght;
      end
      case (state)
        st_idle: begin
          if (armed && sel_vld_c) begin
            state   <= st_busy;
            gnt     <= drvrs'(1) << sel_id_c;
            gnt_vld <= 1'b1;
            gnt_id  <= sel_id_c;
            tcnt    <= '0;
          end
        end
        st_busy: begin
          if (rel_c) begin
            state       <= st_idle;
            gnt         <= '0;
            gnt_vld     <= 1'b0;
            ptr         <= (32'(gnt_id) == drvrs - 1) ? '0 : gnt_id + idx_w'(1);
            timeout_err <= !done;
          end else begin
            tcnt <= tcnt + tcnt_w'(1);
          end
        end
        default: state <= st_idle;
      endcase
    end
  end

endmodule

// File: doc/bus_wrr_scheduler.md
BUS_WRR_SCHEDULER -- requirements
Module: bus_wrr_scheduler

Interface
REQ-001 Parameter drvrs, default 4: number of requesting drivers on the shared bus.
REQ-002 Parameter wght_w, default 4: width of each per-driver weight/credit field.
REQ-003 Parameter timeout, default 16: maximum BUSY cycles before forced release, in the range 2..255.
REQ-004 Port clk, in, 1: single clock; all state updates on its rising edge.
REQ-005 Port reset, in, 1: asynchronous active-low reset.
REQ-006 Port pndng, in, drvrs: per-driver pending-request flags.
REQ-007 Port done, in, 1: bus reports that the granted transfer completed this cycle.
REQ-008 Port cfg_we, in, 1: weight write strobe.
REQ-009 Port cfg_idx, in, $clog2(drvrs): index of the driver whose weight is written.
REQ-010 Port cfg_wght, in, wght_w: weight value to write.
REQ-011 Port gnt, out, drvrs: one-hot registered grant.
REQ-012 Port gnt_vld, out, 1: high while any grant is held.
REQ-013 Port gnt_id, out, $clog2(drvrs): binary index of the granted driver; valid only while gnt_vld=1.
REQ-014 Port timeout_err, out, 1: one-cycle pulse on a forced release.

Function
REQ-015 Per-driver state: weight[i], credit[i], a round-robin pointer ptr, an FSM with states IDLE and BUSY, and a cycle counter tcnt.
REQ-016 Eligible(i) = pndng[i] & (weight[i]!=0); weight 0 masks driver i immediately.
REQ-017 In IDLE with no eligible driver: remain in IDLE; gnt=0.
REQ-018 In IDLE with an eligible driver: select the first eligible i with credit[i]!=0, searching from ptr upward with wrap from drvrs-1 to 0.
REQ-019 If every eligible driver has credit 0: load credit[k]=weight[k] for all k in the same cycle, then select by REQ-018 with no added latency.
REQ-020 Timing: the selection occurs in IDLE at cycle t; gnt[i], gnt_vld and gnt_id are asserted at t+1, the state is BUSY, and tcnt=0.
REQ-021 In BUSY: gnt is held stable regardless of pndng changes; tcnt increments every cycle.
REQ-022 Release on done=1 in BUSY at cycle t: gnt=0 and the state is IDLE at t+1; credit[g] decrements by 1; ptr=(g+1) mod drvrs; the next grant can appear no earlier than t+2.
REQ-023 Release when tcnt reaches timeout-1 without done: release as in REQ-022 (credit decremented, ptr advanced) and pulse timeout_err=1 at t+1 for exactly one cycle.
REQ-024 If done and the timeout coincide in the same cycle: treat as a normal done; no timeout_err.
REQ-025 done while in IDLE: ignored.
REQ-026 credit never underflows; a decrement at 0 holds 0.
REQ-027 cfg_we=1: weight[cfg_idx] <= cfg_wght at the clock edge; credit is unchanged except that credit[cfg_idx] is clamped to min(credit, cfg_wght).
REQ-028 A config write during BUSY does not affect the held grant.
REQ-029 At most one gnt bit is ever high; gnt_id always equals the encoded value of gnt while gnt_vld=1.

Reset
REQ-030 reset=0 asynchronously forces: state IDLE, gnt=0, gnt_vld=0, gnt_id=0, timeout_err=0, tcnt=0, ptr=0, weight[i]=1, credit[i]=1 for all i.
REQ-031 Reset asserted while in BUSY: the grant drops immediately without waiting for a clock, and no credit update occurs.
REQ-032 After reset deasserts, the first grant can occur at the second rising edge.

Verification
REQ-033 Default weights, pndng=4'b1111, done pulsed 2 cycles after each grant -> grant order 0,1,2,3,0,1,... with gnt_vld gaps of exactly 1 cycle.
REQ-034 Weights {3,1,1,1}, pndng=4'b1111 held, done after every grant -> per refill round: 0,1,2,3,0,0, then repeat.
REQ-035 pndng=4'b0100, done never asserted, timeout=16 -> gnt=4'b0100 held 16 cycles, then timeout_err pulses once, gnt=0, and a regrant to 2 follows after credit refill.
REQ-036 Write weight[1]=0 while pndng=4'b0011 -> driver 1 is never granted; only 0 is granted; gnt stays one-hot.
REQ-037 Assert reset=0 mid-BUSY on driver 3 -> gnt=0 immediately; after release, the first grant goes to driver 0 (ptr=0).
REQ-038 done and the timeout in the same cycle -> release with timeout_err=0.
